// File: rtl/mem_bus_sram.sv
// Data-memory bus responder backed by an on-chip 64-bit array.
// Serves one transaction at a time after a fixed number of wait states.
module mem_bus_sram #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic        mem_req_i,
    input  logic [63:0] mem_addr_i,
    input  logic [1:0]  mem_size_i,
    input  logic [63:0] mem_data_write_i,
    output logic        mem_ready_o,
    output logic [63:0] mem_data_read_o,
    output logic [1:0]  mem_resp_o
);

    localparam int          IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [63:0] LIMIT_ADDR  = BASE_ADDR + (64'(DEPTH_WORDS) << 3);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic [63:0] size_mask(input logic [1:0] size);
        logic [63:0] m;
        case (size)
            2'b00:   m = 64'h0000_0000_0000_00FF;
            2'b01:   m = 64'h0000_0000_0000_FFFF;
            2'b10:   m = 64'h0000_0000_FFFF_FFFF;
            2'b11:   m = 64'hFFFF_FFFF_FFFF_FFFF;
            default: m = 64'h0000_0000_0000_0000;
        endcase
        return m;
    endfunction

    function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] offset);
        logic ok;
        case (size)
            2'b00:   ok = 1'b1;
            2'b01:   ok = (offset[0] == 1'b0);
            2'b10:   ok = (offset[1:0] == 2'b00);
            2'b11:   ok = (offset == 3'b000);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic        req_r;
    logic [63:0] addr_r;
    logic [1:0]  size_r;
    logic [63:0] wdata_r;
    logic        ready_r;
    logic [63:0] rdata_r;
    logic [1:0]  resp_r;
    logic [63:0] mem_r [DEPTH_WORDS];

    logic [63:0]      dec_addr_s;
    logic [1:0]       dec_size_s;
    logic             dec_req_s;
    logic [2:0]       offset_s;
    logic [IDX_W-1:0] index_s;
    logic             in_range_s;
    logic [1:0]       resp_s;
    logic [63:0]      rd_word_s;
    logic [63:0]      rd_out_s;
    logic [63:0]      wmask_s;
    logic [63:0]      wmerge_s;
    logic             wr_en_s;

    // Decode: in IDLE the live request is decoded so a zero-wait read can sample the array on acceptance.
    always_comb begin
        dec_addr_s = addr_r;
        dec_size_s = size_r;
        dec_req_s  = req_r;
        if (state_r == ST_IDLE) begin
            dec_addr_s = mem_addr_i;
            dec_size_s = mem_size_i;
            dec_req_s  = mem_req_i;
        end else begin
            dec_addr_s = addr_r;
            dec_size_s = size_r;
            dec_req_s  = req_r;
        end
        offset_s   = dec_addr_s[2:0];
        index_s    = IDX_W'((dec_addr_s - BASE_ADDR) >> 3);
        in_range_s = (dec_addr_s >= BASE_ADDR) && (dec_addr_s < LIMIT_ADDR);
        if (!in_range_s) begin
            resp_s = RESP_DECERR;
        end else if (!is_aligned(dec_size_s, offset_s)) begin
            resp_s = RESP_SLVERR;
        end else begin
            resp_s = RESP_OKAY;
        end
        rd_word_s = mem_r[index_s];
        if (!dec_req_s && (resp_s == RESP_OKAY)) begin
            rd_out_s = (rd_word_s >> {offset_s, 3'b000}) & size_mask(dec_size_s);
        end else begin
            rd_out_s = 64'd0;
        end
        wmask_s  = size_mask(dec_size_s) << {offset_s, 3'b000};
        wmerge_s = (rd_word_s & ~wmask_s) | ((wdata_r << {offset_s, 3'b000}) & wmask_s);
        wr_en_s  = (state_r == ST_RESP) && req_r && (resp_s == RESP_OKAY) && !rst;
    end

    // Transaction FSM with registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            req_r   <= 1'b0;
            addr_r  <= 64'd0;
            size_r  <= 2'b00;
            wdata_r <= 64'd0;
            ready_r <= 1'b0;
            rdata_r <= 64'd0;
            resp_r  <= RESP_OKAY;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ready_r <= 1'b0;
                    rdata_r <= 64'd0;
                    resp_r  <= RESP_OKAY;
                    if (mem_valid_i) begin
                        req_r   <= mem_req_i;
                        addr_r  <= mem_addr_i;
                        size_r  <= mem_size_i;
                        wdata_r <= mem_data_write_i;
                        cnt_r   <= 4'(WAIT_CYCLES);
                        if (WAIT_CYCLES == 0) begin
                            state_r <= ST_RESP;
                            ready_r <= 1'b1;
                            rdata_r <= rd_out_s;
                            resp_r  <= resp_s;
                        end else begin
                            state_r <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r - 4'd1;
                    if (cnt_r == 4'd1) begin
                        state_r <= ST_RESP;
                        ready_r <= 1'b1;
                        rdata_r <= rd_out_s;
                        resp_r  <= resp_s;
                    end else begin
                        ready_r <= 1'b0;
                        rdata_r <= 64'd0;
                        resp_r  <= RESP_OKAY;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 4'd0;
                    ready_r <= 1'b0;
                    rdata_r <= 64'd0;
                    resp_r  <= RESP_OKAY;
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 4'd0;
                    ready_r <= 1'b0;
                    rdata_r <= 64'd0;
                    resp_r  <= RESP_OKAY;
                end
            endcase
        end
    end

    // Array write port: commits at the edge that ends RESP, suppressed by reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[index_s] <= wmerge_s;
        end
    end

    assign mem_ready_o     = ready_r;
    assign mem_data_read_o = rdata_r;
    assign mem_resp_o      = resp_r;

endmodule

// File: tb/tb_mem_bus_sram.sv
// Directed-vector bench for mem_bus_sram with default parameters (WAIT_CYCLES = 2).
module tb_mem_bus_sram;

    logic        clk;
    logic        rst;
    logic        mem_valid_i;
    logic        mem_req_i;
    logic [63:0] mem_addr_i;
    logic [1:0]  mem_size_i;
    logic [63:0] mem_data_write_i;
    logic        mem_ready_o;
    logic [63:0] mem_data_read_o;
    logic [1:0]  mem_resp_o;

    int vec_cnt_r;
    int err_cnt_r;

    mem_bus_sram dut (
        .clk              (clk),
        .rst              (rst),
        .mem_valid_i      (mem_valid_i),
        .mem_req_i        (mem_req_i),
        .mem_addr_i       (mem_addr_i),
        .mem_size_i       (mem_size_i),
        .mem_data_write_i (mem_data_write_i),
        .mem_ready_o      (mem_ready_o),
        .mem_data_read_o  (mem_data_read_o),
        .mem_resp_o       (mem_resp_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt_r++;
        if (obs !== exp) begin
            err_cnt_r++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus transaction; returns captured read data, resp and cycles from acceptance to ready.
    task automatic txn(input logic wr, input logic [63:0] a, input logic [1:0] sz,
                       input logic [63:0] wd, output logic [63:0] rd,
                       output logic [1:0] rs, output int lat);
        lat = 0;
        rd  = 64'd0;
        rs  = 2'b00;
        @(negedge clk);
        check_val("idle_ready_low", {63'd0, mem_ready_o}, 64'd0);
        mem_valid_i      = 1'b1;
        mem_req_i        = wr;
        mem_addr_i       = a;
        mem_size_i       = sz;
        mem_data_write_i = wd;
        @(posedge clk);
        #1;
        mem_valid_i      = 1'b0;
        mem_addr_i       = 64'h0000_0000_8000_0010;
        mem_data_write_i = 64'hDEAD_BEEF_DEAD_BEEF;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (mem_ready_o) begin
                lat = k;
                rd  = mem_data_read_o;
                rs  = mem_resp_o;
                break;
            end
        end
    endtask

    task automatic access(input string tag, input logic wr, input logic [63:0] a,
                          input logic [1:0] sz, input logic [63:0] wd,
                          input logic [63:0] exp_d, input logic [1:0] exp_r);
        logic [63:0] rd;
        logic [1:0]  rs;
        int          lat;
        txn(wr, a, sz, wd, rd, rs, lat);
        check_val({tag, "_lat"}, 64'(lat), 64'd3);
        check_val({tag, "_data"}, rd, exp_d);
        check_val({tag, "_resp"}, {62'd0, rs}, {62'd0, exp_r});
    endtask

    initial begin
        logic [63:0] rd;
        logic [1:0]  rs;
        int          lat;
        vec_cnt_r        = 0;
        err_cnt_r        = 0;
        rst              = 1'b1;
        mem_valid_i      = 1'b0;
        mem_req_i        = 1'b0;
        mem_addr_i       = 64'd0;
        mem_size_i       = 2'b00;
        mem_data_write_i = 64'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_ready", {63'd0, mem_ready_o}, 64'd0);
        check_val("rst_data", mem_data_read_o, 64'd0);
        check_val("rst_resp", {62'd0, mem_resp_o}, 64'd0);
        rst = 1'b0;

        // Latency: read contents undefined, only timing and resp checked.
        txn(1'b0, 64'h0000_0000_8000_0000, 2'b11, 64'd0, rd, rs, lat);
        check_val("lat_read", 64'(lat), 64'd3);
        check_val("lat_resp", {62'd0, rs}, 64'd0);

        access("wr_dword", 1'b1, 64'h0000_0000_8000_0010, 2'b11, 64'h1122_3344_5566_7788, 64'd0, 2'b00);
        access("rd_dword", 1'b0, 64'h0000_0000_8000_0010, 2'b11, 64'd0, 64'h1122_3344_5566_7788, 2'b00);
        access("wr_byte", 1'b1, 64'h0000_0000_8000_0015, 2'b00, 64'h0000_0000_0000_00AB, 64'd0, 2'b00);
        access("rd_merge", 1'b0, 64'h0000_0000_8000_0010, 2'b11, 64'd0, 64'h1122_AB44_5566_7788, 2'b00);
        access("rd_byte", 1'b0, 64'h0000_0000_8000_0015, 2'b00, 64'd0, 64'h0000_0000_0000_00AB, 2'b00);
        access("rd_half", 1'b0, 64'h0000_0000_8000_0014, 2'b01, 64'd0, 64'h0000_0000_0000_AB44, 2'b00);
        access("rd_word", 1'b0, 64'h0000_0000_8000_0014, 2'b10, 64'd0, 64'h0000_0000_1122_AB44, 2'b00);

        access("wr_misal", 1'b1, 64'h0000_0000_8000_0011, 2'b01, 64'h0000_0000_0000_FFFF, 64'd0, 2'b10);
        access("rd_misal", 1'b0, 64'h0000_0000_8000_0012, 2'b10, 64'd0, 64'd0, 2'b10);
        access("rd_after_misal", 1'b0, 64'h0000_0000_8000_0010, 2'b11, 64'd0, 64'h1122_AB44_5566_7788, 2'b00);

        access("rd_below", 1'b0, 64'h0000_0000_7FFF_FFF8, 2'b11, 64'd0, 64'd0, 2'b11);
        access("rd_above", 1'b0, 64'h0000_0000_8000_2000, 2'b11, 64'd0, 64'd0, 2'b11);
        access("wr_above", 1'b1, 64'h0000_0000_8000_2000, 2'b11, 64'h0123_4567_89AB_CDEF, 64'd0, 2'b11);
        access("wr_last", 1'b1, 64'h0000_0000_8000_1FF8, 2'b11, 64'hCAFE_F00D_0BAD_BEEF, 64'd0, 2'b00);
        access("rd_last", 1'b0, 64'h0000_0000_8000_1FF8, 2'b11, 64'd0, 64'hCAFE_F00D_0BAD_BEEF, 2'b00);

        // Reset during WAIT: transaction abandoned, no write.
        @(negedge clk);
        mem_valid_i      = 1'b1;
        mem_req_i        = 1'b1;
        mem_addr_i       = 64'h0000_0000_8000_0010;
        mem_size_i       = 2'b00;
        mem_data_write_i = 64'h0000_0000_0000_00FF;
        @(posedge clk);
        #1;
        mem_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("rstw_ready", {63'd0, mem_ready_o}, 64'd0);
        check_val("rstw_data", mem_data_read_o, 64'd0);
        check_val("rstw_resp", {62'd0, mem_resp_o}, 64'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_val("rstw_no_pulse", {63'd0, mem_ready_o}, 64'd0);
        end
        access("rd_after_rstw", 1'b0, 64'h0000_0000_8000_0010, 2'b11, 64'd0, 64'h1122_AB44_5566_7788, 2'b00);

        // Reset coinciding with RESP: the write must not commit.
        @(negedge clk);
        mem_valid_i      = 1'b1;
        mem_req_i        = 1'b1;
        mem_addr_i       = 64'h0000_0000_8000_0010;
        mem_size_i       = 2'b00;
        mem_data_write_i = 64'h0000_0000_0000_00FF;
        @(posedge clk);
        #1;
        mem_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rstr_in_resp", {63'd0, mem_ready_o}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_val("rstr_ready", {63'd0, mem_ready_o}, 64'd0);
        rst = 1'b0;
        access("rd_after_rstr", 1'b0, 64'h0000_0000_8000_0010, 2'b11, 64'd0, 64'h1122_AB44_5566_7788, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt_r, err_cnt_r);
        $finish;
    end

endmodule
